// File: rtl/bgp_seq_pkg.sv
// Shared types for the bandgap enable sequencer: per-channel state encoding
// and the default settle/timeout counter width.
package bgp_seq_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_WAIT,
        ST_SETTLE,
        ST_CHECK,
        ST_ON,
        ST_FAULT
    } bgp_state_t;

endpackage

// File: rtl/bgp_chan_ctrl.sv
// One bandgap channel: ok synchroniser, power-up FSM, settle/timeout counter
// and the drop counter that watches the comparator once the channel is ON.
module bgp_chan_ctrl
    import bgp_seq_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SETTLE_CYC  = 1000,
    parameter int TIMEOUT_CYC = 4000,
    parameter int DROP_CYC    = 4,
    parameter int SYNC_STG    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       grant,
    input  logic       req,
    input  logic       ok_raw,
    input  logic       clr,
    output logic [2:0] state,
    output logic       token,
    output logic       en,
    output logic       ready,
    output logic       fault
);

    localparam int DROP_W = $clog2(DROP_CYC + 1);

    logic [SYNC_STG-1:0] sync;
    logic                ok_s;
    bgp_state_t          cur;
    bgp_state_t          nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [CNT_W-1:0]    cnt_inc;
    logic [DROP_W-1:0]   drop;
    logic [DROP_W-1:0]   drop_nxt;
    logic [DROP_W-1:0]   drop_inc;
    logic                token_nxt;
    logic                en_nxt;
    logic                ready_nxt;
    logic                fault_nxt;

    generate
        if (SYNC_STG == 1) begin : g_sync_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sync <= '0;
                else        sync <= ok_raw;
            end
        end else begin : g_sync_chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sync <= '0;
                else        sync <= {sync[SYNC_STG-2:0], ok_raw};
            end
        end
    endgenerate

    assign ok_s     = sync[SYNC_STG-1];
    assign cnt_inc  = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    assign drop_inc = (drop == '1) ? drop : drop + DROP_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur   <= ST_OFF;
            cnt   <= '0;
            drop  <= '0;
            token <= 1'b0;
            en    <= 1'b0;
            ready <= 1'b0;
            fault <= 1'b0;
        end else begin
            cur   <= nxt;
            cnt   <= cnt_nxt;
            drop  <= drop_nxt;
            token <= token_nxt;
            en    <= en_nxt;
            ready <= ready_nxt;
            fault <= fault_nxt;
        end
    end

    // Fault entry is tested before req so a dropping request never hides a fault.
    always_comb begin
        nxt      = cur;
        cnt_nxt  = cnt;
        drop_nxt = drop;
        case (cur)
            ST_OFF: begin
                if (req) nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (!req)       nxt = ST_OFF;
                else if (grant) nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!req)                                 nxt = ST_OFF;
                else if (cnt == CNT_W'(SETTLE_CYC - 1))   nxt = ST_CHECK;
                else                                      cnt_nxt = cnt_inc;
            end
            ST_CHECK: begin
                if (!ok_s && cnt == CNT_W'(TIMEOUT_CYC - 1)) nxt = ST_FAULT;
                else if (!req)                               nxt = ST_OFF;
                else if (ok_s)                               nxt = ST_ON;
                else                                         cnt_nxt = cnt_inc;
            end
            ST_ON: begin
                if (!ok_s && drop_inc == DROP_W'(DROP_CYC)) nxt = ST_FAULT;
                else if (!req)                              nxt = ST_OFF;
                else                                        drop_nxt = ok_s ? '0 : drop_inc;
            end
            ST_FAULT: begin
                if (clr) nxt = ST_OFF;
            end
            default: nxt = ST_OFF;
        endcase
        if (nxt != cur) begin
            cnt_nxt  = '0;
            drop_nxt = '0;
        end
    end

    always_comb begin
        token_nxt = (nxt == ST_SETTLE) || (nxt == ST_CHECK);
        en_nxt    = (nxt == ST_SETTLE) || (nxt == ST_CHECK) || (nxt == ST_ON);
        ready_nxt = (nxt == ST_ON);
        fault_nxt = (nxt == ST_FAULT);
    end

    assign state = cur;

endmodule

// File: rtl/bgp_enable_sequencer.sv
// Powers N_CH bandgap macros up one at a time: a single start token is handed
// to the lowest-index waiting channel whenever no channel is settling or checking.
module bgp_enable_sequencer
    import bgp_seq_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SETTLE_CYC  = 1000,
    parameter int TIMEOUT_CYC = 4000,
    parameter int DROP_CYC    = 4,
    parameter int SYNC_STG    = 2
) (
    input  logic            wb_clk_i,
    input  logic            resetb,
    input  logic [N_CH-1:0] req_i,
    input  logic [N_CH-1:0] ok_i,
    input  logic [N_CH-1:0] clr_fault_i,
    output logic [N_CH-1:0] en_o,
    output logic [N_CH-1:0] ready_o,
    output logic [N_CH-1:0] fault_o,
    output logic            busy_o
);

    logic [2:0]      chan_state [N_CH];
    logic [N_CH-1:0] waiting;
    logic [N_CH-1:0] token;
    logic [N_CH-1:0] grant;

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_chan
            bgp_chan_ctrl #(
                .CNT_W       (CNT_W),
                .SETTLE_CYC  (SETTLE_CYC),
                .TIMEOUT_CYC (TIMEOUT_CYC),
                .DROP_CYC    (DROP_CYC),
                .SYNC_STG    (SYNC_STG)
            ) u_chan (
                .clk    (wb_clk_i),
                .rst_n  (resetb),
                .grant  (grant[g]),
                .req    (req_i[g]),
                .ok_raw (ok_i[g]),
                .clr    (clr_fault_i[g]),
                .state  (chan_state[g]),
                .token  (token[g]),
                .en     (en_o[g]),
                .ready  (ready_o[g]),
                .fault  (fault_o[g])
            );
            assign waiting[g] = (chan_state[g] == ST_WAIT);
        end
    endgenerate

    // Two's-complement trick isolates the lowest set bit, i.e. fixed priority to channel 0.
    assign busy_o = |token;
    assign grant  = busy_o ? '0 : (waiting & (~waiting + N_CH'(1)));

endmodule

// File: tb/tb_bgp_enable_sequencer.sv
// Table-driven bench for the two-channel sequencer with short settle/timeout
// values; expected outputs go through a scoreboard queue and are checked after each step.
module tb_bgp_enable_sequencer;

    typedef struct {
        logic [1:0] req;
        logic [1:0] ok;
        logic [1:0] clr;
        int         cycles;
        logic [1:0] en;
        logic [1:0] ready;
        logic [1:0] fault;
        logic       busy;
        string      name;
    } vec_t;

    typedef struct {
        logic [1:0] en;
        logic [1:0] ready;
        logic [1:0] fault;
        logic       busy;
        string      name;
    } exp_t;

    logic       clk;
    logic       resetb;
    logic [1:0] req_i;
    logic [1:0] ok_i;
    logic [1:0] clr_fault_i;
    logic [1:0] en_o;
    logic [1:0] ready_o;
    logic [1:0] fault_o;
    logic       busy_o;

    int   n_compared;
    int   n_mismatched;
    exp_t sb[$];
    vec_t vecs[$];

    bgp_enable_sequencer #(
        .N_CH        (2),
        .CNT_W       (16),
        .SETTLE_CYC  (8),
        .TIMEOUT_CYC (16),
        .DROP_CYC    (4),
        .SYNC_STG    (2)
    ) dut (
        .wb_clk_i    (clk),
        .resetb      (resetb),
        .req_i       (req_i),
        .ok_i        (ok_i),
        .clr_fault_i (clr_fault_i),
        .en_o        (en_o),
        .ready_o     (ready_o),
        .fault_o     (fault_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: run did not finish, actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [1:0] req, input logic [1:0] ok, input logic [1:0] clr,
                                input int cycles, input logic [1:0] en, input logic [1:0] ready,
                                input logic [1:0] fault, input logic busy, input string name);
        vec_t v;
        v.req = req; v.ok = ok; v.clr = clr; v.cycles = cycles;
        v.en = en; v.ready = ready; v.fault = fault; v.busy = busy; v.name = name;
        return v;
    endfunction

    task automatic pushExpect(input logic [1:0] en, input logic [1:0] ready,
                              input logic [1:0] fault, input logic busy, input string name);
        exp_t e;
        e.en = en; e.ready = ready; e.fault = fault; e.busy = busy; e.name = name;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        n_compared++;
        if (sb.size() == 0) begin
            n_mismatched++;
            $display("[TB] FAIL scoreboard_empty: actual=empty required=entry");
        end else begin
            e = sb.pop_front();
            if ({en_o, ready_o, fault_o, busy_o} !== {e.en, e.ready, e.fault, e.busy}) begin
                n_mismatched++;
                $display("[TB] FAIL %s: actual en=%b ready=%b fault=%b busy=%b, required en=%b ready=%b fault=%b busy=%b",
                         e.name, en_o, ready_o, fault_o, busy_o, e.en, e.ready, e.fault, e.busy);
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req_i       = v.req;
        ok_i        = v.ok;
        clr_fault_i = v.clr;
        pushExpect(v.en, v.ready, v.fault, v.busy, v.name);
        repeat (v.cycles) @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        resetb       = 1'b0;
        req_i        = 2'b00;
        ok_i         = 2'b00;
        clr_fault_i  = 2'b00;

        // Single channel power-up with the comparator already good
        vecs.push_back(mk(2'b00, 2'b01, 2'b00, 2, 2'b00, 2'b00, 2'b00, 1'b0, "idle"));
        vecs.push_back(mk(2'b01, 2'b01, 2'b00, 1, 2'b00, 2'b00, 2'b00, 1'b0, "t1_wait"));
        vecs.push_back(mk(2'b01, 2'b01, 2'b00, 1, 2'b01, 2'b00, 2'b00, 1'b1, "t1_en"));
        vecs.push_back(mk(2'b01, 2'b01, 2'b00, 7, 2'b01, 2'b00, 2'b00, 1'b1, "t1_settle_end"));
        vecs.push_back(mk(2'b01, 2'b01, 2'b00, 1, 2'b01, 2'b00, 2'b00, 1'b1, "t1_check"));
        vecs.push_back(mk(2'b01, 2'b01, 2'b00, 1, 2'b01, 2'b01, 2'b00, 1'b0, "t1_on"));
        // Both requested together: ch0 first, ch1 once ch0 is ON
        vecs.push_back(mk(2'b00, 2'b11, 2'b00, 1, 2'b00, 2'b00, 2'b00, 1'b0, "t2_off"));
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 1, 2'b00, 2'b00, 2'b00, 1'b0, "t2_wait"));
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 1, 2'b01, 2'b00, 2'b00, 1'b1, "t2_ch0_grant"));
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 8, 2'b01, 2'b00, 2'b00, 1'b1, "t2_ch0_check"));
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 1, 2'b01, 2'b01, 2'b00, 1'b0, "t2_ch0_on"));
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 1, 2'b11, 2'b01, 2'b00, 1'b1, "t2_ch1_grant"));
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 8, 2'b11, 2'b01, 2'b00, 1'b1, "t2_ch1_check"));
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 1, 2'b11, 2'b11, 2'b00, 1'b0, "t2_both_on"));
        // ch0 times out in CHECK, token moves to ch1, then fault is cleared
        vecs.push_back(mk(2'b00, 2'b10, 2'b00, 1, 2'b00, 2'b00, 2'b00, 1'b0, "t3_off"));
        vecs.push_back(mk(2'b11, 2'b10, 2'b00, 1, 2'b00, 2'b00, 2'b00, 1'b0, "t3_wait"));
        vecs.push_back(mk(2'b11, 2'b10, 2'b00, 1, 2'b01, 2'b00, 2'b00, 1'b1, "t3_ch0_grant"));
        vecs.push_back(mk(2'b11, 2'b10, 2'b00, 8, 2'b01, 2'b00, 2'b00, 1'b1, "t3_ch0_check"));
        vecs.push_back(mk(2'b11, 2'b10, 2'b00, 15, 2'b01, 2'b00, 2'b00, 1'b1, "t3_check_last"));
        vecs.push_back(mk(2'b11, 2'b10, 2'b00, 1, 2'b00, 2'b00, 2'b01, 1'b0, "t3_fault"));
        vecs.push_back(mk(2'b11, 2'b10, 2'b00, 1, 2'b10, 2'b00, 2'b01, 1'b1, "t3_ch1_grant"));
        vecs.push_back(mk(2'b11, 2'b10, 2'b01, 1, 2'b10, 2'b00, 2'b00, 1'b1, "t3_clr"));
        vecs.push_back(mk(2'b11, 2'b10, 2'b00, 1, 2'b10, 2'b00, 2'b00, 1'b1, "t3_rewait"));
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 6, 2'b10, 2'b00, 2'b00, 1'b1, "t3_ch1_check"));
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 1, 2'b10, 2'b10, 2'b00, 1'b0, "t3_ch1_on"));
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 1, 2'b11, 2'b10, 2'b00, 1'b1, "t3_ch0_regrant"));
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 9, 2'b11, 2'b11, 2'b00, 1'b0, "t3_both_on"));
        // Comparator glitches while ON: 3 low cycles tolerated, 4 faults
        vecs.push_back(mk(2'b11, 2'b10, 2'b00, 3, 2'b11, 2'b11, 2'b00, 1'b0, "t4_low3"));
        vecs.push_back(mk(2'b11, 2'b11, 2'b00, 4, 2'b11, 2'b11, 2'b00, 1'b0, "t4_recover"));
        vecs.push_back(mk(2'b11, 2'b10, 2'b00, 4, 2'b11, 2'b11, 2'b00, 1'b0, "t4_low4_a"));
        vecs.push_back(mk(2'b11, 2'b10, 2'b00, 1, 2'b11, 2'b11, 2'b00, 1'b0, "t4_drop3"));
        vecs.push_back(mk(2'b11, 2'b10, 2'b00, 1, 2'b10, 2'b10, 2'b01, 1'b0, "t4_fault"));
        vecs.push_back(mk(2'b00, 2'b11, 2'b01, 1, 2'b00, 2'b00, 2'b00, 1'b0, "t4_clr"));
        // Request dropped mid-SETTLE, then a full restart; clr ignored outside FAULT
        vecs.push_back(mk(2'b01, 2'b11, 2'b00, 1, 2'b00, 2'b00, 2'b00, 1'b0, "t5_wait"));
        vecs.push_back(mk(2'b01, 2'b11, 2'b00, 5, 2'b01, 2'b00, 2'b00, 1'b1, "t5_cnt4"));
        vecs.push_back(mk(2'b00, 2'b11, 2'b00, 1, 2'b00, 2'b00, 2'b00, 1'b0, "t5_drop"));
        vecs.push_back(mk(2'b01, 2'b11, 2'b00, 2, 2'b01, 2'b00, 2'b00, 1'b1, "t5_restart"));
        vecs.push_back(mk(2'b01, 2'b11, 2'b00, 7, 2'b01, 2'b00, 2'b00, 1'b1, "t5_settle_full"));
        vecs.push_back(mk(2'b01, 2'b11, 2'b01, 1, 2'b01, 2'b00, 2'b00, 1'b1, "t5_check"));
        vecs.push_back(mk(2'b01, 2'b11, 2'b00, 1, 2'b01, 2'b01, 2'b00, 1'b0, "t5_on"));
        // Bring ch1 into CHECK with its comparator low, ready for the reset pulse
        vecs.push_back(mk(2'b11, 2'b01, 2'b00, 1, 2'b01, 2'b01, 2'b00, 1'b0, "t6_ch1_wait"));
        vecs.push_back(mk(2'b11, 2'b01, 2'b00, 1, 2'b11, 2'b01, 2'b00, 1'b1, "t6_ch1_grant"));
        vecs.push_back(mk(2'b11, 2'b01, 2'b00, 8, 2'b11, 2'b01, 2'b00, 1'b1, "t6_ch1_check"));

        @(posedge clk);
        #2;
        pushExpect(2'b00, 2'b00, 2'b00, 1'b0, "reset_state");
        checkOutput();
        @(posedge clk);
        #1;
        resetb = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // Asynchronous reset in the middle of a cycle, far from any clock edge
        #2;
        resetb = 1'b0;
        #1;
        pushExpect(2'b00, 2'b00, 2'b00, 1'b0, "t6_async_reset");
        checkOutput();
        @(posedge clk);
        #1;
        pushExpect(2'b00, 2'b00, 2'b00, 1'b0, "t6_reset_held");
        checkOutput();
        resetb = 1'b1;
        applyStimulus(mk(2'b01, 2'b11, 2'b00, 1, 2'b00, 2'b00, 2'b00, 1'b0, "t6_rst_wait"));
        applyStimulus(mk(2'b01, 2'b11, 2'b00, 1, 2'b01, 2'b00, 2'b00, 1'b1, "t6_rst_grant"));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
